dual_alignment_top: RTL and testbench

Two-lane byte aligner with a shared status word. Each cycle it accepts two 64-bit data words and one 8-bit control byte. It realigns each lane across its current and previous word by a per-lane byte offset, and presents the registered aligned words together with counters and check fields on one 159-bit flat output bus. It is a self-contained top level for datapath alignment and regression runs: flat packed input, flat packed output, no handshake back-pressure.

---
 rtl/dual_align_pkg.sv | 37 +++
 rtl/dual_alignment_lane_aligner.sv | 35 +++
 rtl/dual_alignment_top.sv | 71 +++++++
 tb/tb_dual_alignment_top.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dual_align_pkg.sv
// Shared widths, flat-bus field positions and the byte XOR fold used by
// the two-lane byte aligner.
package dual_align_pkg;

   localparam int LANE_W = 64;
   localparam int OFF_W  = 3;
   localparam int CNT_W  = 16;
   localparam int CHK_W  = 8;

   localparam int IN_LANE_A_LSB = 0;
   localparam int IN_LANE_B_LSB = 64;
   localparam int IN_OFF_A_LSB  = 128;
   localparam int IN_OFF_B_LSB  = 131;
   localparam int IN_VALID_BIT  = 134;
   localparam int IN_CLR_BIT    = 135;
   localparam int IN_W          = 136;

   localparam int OUT_AL_A_LSB  = 0;
   localparam int OUT_AL_B_LSB  = 64;
   localparam int OUT_OFF_A_LSB = 128;
   localparam int OUT_OFF_B_LSB = 131;
   localparam int OUT_MATCH_BIT = 134;
   localparam int OUT_CNT_LSB   = 135;
   localparam int OUT_CHK_LSB   = 151;
   localparam int OUT_W         = 159;

   function automatic logic [CHK_W-1:0] byte_xor16(input logic [LANE_W-1:0] a,
                                                   input logic [LANE_W-1:0] b);
      logic [CHK_W-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < LANE_W / 8; i++) begin
         r = r ^ a[8*i +: 8] ^ b[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dual_alignment_lane_aligner.sv
// One lane: keeps the previously accepted word and registers the byte-offset
// slice of the {current, previous} window on each accept.
module lane_aligner
   import dual_align_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              valid,
   input  logic [LANE_W-1:0] lane,
   input  logic [OFF_W-1:0]  off,
   output logic [LANE_W-1:0] nxt,
   output logic [LANE_W-1:0] al
);

   logic [LANE_W-1:0]   prev;
   logic [2*LANE_W-1:0] win;

   assign win = {lane, prev};
   assign nxt = win[{off, 3'b000} +: LANE_W];

   // clr only wipes the history; the last aligned word stays visible
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev <= '0;
         al   <= '0;
      end else if (clr) begin
         prev <= '0;
      end else if (valid) begin
         prev <= lane;
         al   <= nxt;
      end
   end

endmodule

// File: rtl/dual_alignment_top.sv
// Two-lane byte aligner: unpacks the flat input, runs both lanes, and
// registers accept counter, lane-equality flag and XOR check byte.
module dual_alignment_top
   import dual_align_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IN_W-1:0]  in_flat,
   output logic [OUT_W-1:0] out_flat
);

   logic [LANE_W-1:0] lane_a, lane_b;
   logic [OFF_W-1:0]  off_a, off_b;
   logic              valid, clr, accept;
   logic [LANE_W-1:0] nxt_a, nxt_b, al_a, al_b;
   logic [OFF_W-1:0]  off_a_q, off_b_q;
   logic              match;
   logic [CNT_W-1:0]  cnt;
   logic [CHK_W-1:0]  chk;

   assign lane_a = in_flat[IN_LANE_A_LSB +: LANE_W];
   assign lane_b = in_flat[IN_LANE_B_LSB +: LANE_W];
   assign off_a  = in_flat[IN_OFF_A_LSB +: OFF_W];
   assign off_b  = in_flat[IN_OFF_B_LSB +: OFF_W];
   assign valid  = in_flat[IN_VALID_BIT];
   assign clr    = in_flat[IN_CLR_BIT];
   assign accept = valid & ~clr;

   lane_aligner u_lane_a (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .valid (valid),
      .lane  (lane_a),
      .off   (off_a),
      .nxt   (nxt_a),
      .al    (al_a)
   );

   lane_aligner u_lane_b (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .valid (valid),
      .lane  (lane_b),
      .off   (off_b),
      .nxt   (nxt_b),
      .al    (al_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_a_q <= '0;
         off_b_q <= '0;
         match   <= 1'b0;
         cnt     <= '0;
         chk     <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (accept) begin
         off_a_q <= off_a;
         off_b_q <= off_b;
         match   <= (nxt_a == nxt_b);
         cnt     <= cnt + 1'b1;
         chk     <= byte_xor16(nxt_a, nxt_b);
      end
   end

   assign out_flat = {chk, cnt, match, off_b_q, off_a_q, al_b, al_a};

endmodule

// File: tb/tb_dual_alignment_top.sv
// Self-checking bench for dual_alignment_top: directed vector table, random
// traffic against a reference model, async reset and counter wrap.
module tb_dual_alignment_top;

   logic         clk;
   logic         rst_n;
   logic [135:0] in_flat;
   logic [158:0] out_flat;

   int n_cmp;
   int n_bad;

   logic [158:0] exp_q[$];

   logic [63:0] m_prev_a, m_prev_b, m_al_a, m_al_b;
   logic [2:0]  m_oa_q, m_ob_q;
   logic        m_match;
   logic [15:0] m_cnt;
   logic [7:0]  m_chk;

   typedef struct packed {
      logic [63:0] la;
      logic [63:0] lb;
      logic [2:0]  oa;
      logic [2:0]  ob;
      logic        v;
      logic        c;
      logic [63:0] ea;
      logic [63:0] eb;
      logic [2:0]  eoa;
      logic [2:0]  eob;
      logic        em;
      logic [15:0] ecnt;
      logic [7:0]  echk;
   } vec_t;

   vec_t vec[13];

   dual_alignment_top dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_flat  (in_flat),
      .out_flat (out_flat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] ref_align(input logic [63:0] lane,
                                             input logic [63:0] prev,
                                             input logic [2:0] off);
      logic [127:0] w;
      w = {lane, prev} >> (8 * int'(off));
      return w[63:0];
   endfunction

   function automatic logic [7:0] ref_fold(input logic [127:0] w);
      logic [7:0] r;
      r = 8'h00;
      for (int i = 0; i < 16; i++) begin
         r = r ^ w[i*8 +: 8];
      end
      return r;
   endfunction

   function automatic logic [158:0] pack_out(input logic [63:0] a, input logic [63:0] b,
                                             input logic [2:0] oa, input logic [2:0] ob,
                                             input logic m, input logic [15:0] cnt,
                                             input logic [7:0] chk);
      return {chk, cnt, m, ob, oa, b, a};
   endfunction

   task automatic model_reset();
      m_prev_a = '0; m_prev_b = '0; m_al_a = '0; m_al_b = '0;
      m_oa_q = '0; m_ob_q = '0; m_match = 1'b0; m_cnt = '0; m_chk = '0;
   endtask

   task automatic model_step(input logic [63:0] la, input logic [63:0] lb,
                             input logic [2:0] oa, input logic [2:0] ob,
                             input logic v, input logic c);
      logic [63:0] na, nb;
      na = ref_align(la, m_prev_a, oa);
      nb = ref_align(lb, m_prev_b, ob);
      if (c) begin
         m_prev_a = '0; m_prev_b = '0; m_cnt = '0;
      end else if (v) begin
         m_prev_a = la; m_prev_b = lb;
         m_al_a = na; m_al_b = nb;
         m_oa_q = oa; m_ob_q = ob;
         m_match = (na == nb);
         m_cnt = m_cnt + 16'd1;
         m_chk = ref_fold({na, nb});
      end
   endtask

   task automatic check(input string name, input logic [158:0] act, input logic [158:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Drive on falling edge, push expectation, compare just after the rising edge.
   task automatic step(input string name, input logic [63:0] la, input logic [63:0] lb,
                       input logic [2:0] oa, input logic [2:0] ob,
                       input logic v, input logic c,
                       input logic use_exp, input logic [158:0] exp);
      logic [158:0] e;
      @(negedge clk);
      in_flat = {c, v, ob, oa, lb, la};
      model_step(la, lb, oa, ob, v, c);
      exp_q.push_back(use_exp ? exp : pack_out(m_al_a, m_al_b, m_oa_q, m_ob_q, m_match, m_cnt, m_chk));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(name, out_flat, e);
   endtask

   task automatic rand_step(input string name, input int clr_pct);
      logic [63:0] la, lb;
      logic [2:0]  oa, ob;
      logic        v, c;
      la = {$urandom, $urandom};
      lb = ($urandom_range(0, 3) == 0) ? la : {$urandom, $urandom};
      oa = 3'($urandom_range(0, 7));
      ob = ($urandom_range(0, 3) == 0) ? oa : 3'($urandom_range(0, 7));
      v  = ($urandom_range(0, 99) < 75);
      c  = ($urandom_range(0, 99) < clr_pct);
      step(name, la, lb, oa, ob, v, c, 1'b0, '0);
   endtask

   initial begin
      logic [15:0] cnt_seen;
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      in_flat = '0;
      model_reset();

      vec[0]  = '{64'h1111111111111111, 64'h1111111111111111, 3'd0, 3'd0, 1'b1, 1'b0,
                  64'h0, 64'h0, 3'd0, 3'd0, 1'b1, 16'd1, 8'h00};
      vec[1]  = '{64'h2222222222222222, 64'h2222222222222222, 3'd0, 3'd0, 1'b1, 1'b0,
                  64'h1111111111111111, 64'h1111111111111111, 3'd0, 3'd0, 1'b1, 16'd2, 8'h00};
      vec[2]  = '{64'h0706050403020100, 64'h0706050403020100, 3'd0, 3'd0, 1'b1, 1'b0,
                  64'h2222222222222222, 64'h2222222222222222, 3'd0, 3'd0, 1'b1, 16'd3, 8'h00};
      vec[3]  = '{64'h0F0E0D0C0B0A0908, 64'hFFFFFFFFFFFFFFFF, 3'd4, 3'd0, 1'b1, 1'b0,
                  64'h0B0A090807060504, 64'h0706050403020100, 3'd4, 3'd0, 1'b0, 16'd4, 8'h00};
      for (int i = 4; i < 9; i++) begin
         vec[i] = '{64'hDEADBEEFDEADBEEF, 64'hCAFEF00DCAFEF00D, 3'd5, 3'd6, 1'b0, 1'b0,
                    64'h0B0A090807060504, 64'h0706050403020100, 3'd4, 3'd0, 1'b0, 16'd4, 8'h00};
      end
      vec[9]  = '{64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, 3'd1, 3'd7, 1'b1, 1'b0,
                  64'hAA0F0E0D0C0B0A09, 64'hAAAAAAAAAAAAAAFF, 3'd1, 3'd7, 1'b0, 16'd5, 8'hF7};
      vec[10] = '{64'h5555555555555555, 64'h5555555555555555, 3'd2, 3'd3, 1'b1, 1'b1,
                  64'hAA0F0E0D0C0B0A09, 64'hAAAAAAAAAAAAAAFF, 3'd1, 3'd7, 1'b0, 16'd0, 8'hF7};
      vec[11] = '{64'h1234567890ABCDEF, 64'h1234567890ABCDEF, 3'd0, 3'd0, 1'b1, 1'b0,
                  64'h0, 64'h0, 3'd0, 3'd0, 1'b1, 16'd1, 8'h00};
      vec[12] = '{64'h0, 64'h0, 3'd3, 3'd3, 1'b1, 1'b0,
                  64'h0000001234567890, 64'h0000001234567890, 3'd3, 3'd3, 1'b1, 16'd2, 8'h00};

      // Reset held with random inputs, then idle after release
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         in_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
         @(posedge clk);
         #1;
         check("reset_hold", out_flat, '0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step("reset_idle", {$urandom, $urandom}, {$urandom, $urandom}, 3'd5, 3'd2,
              1'b0, 1'b0, 1'b1, '0);
      end

      for (int i = 0; i < 13; i++) begin
         step($sformatf("vec%0d", i), vec[i].la, vec[i].lb, vec[i].oa, vec[i].ob,
              vec[i].v, vec[i].c, 1'b1,
              pack_out(vec[i].ea, vec[i].eb, vec[i].eoa, vec[i].eob, vec[i].em,
                       vec[i].ecnt, vec[i].echk));
      end

      for (int i = 0; i < 60; i++) rand_step("rand", 5);

      // Async reset between edges during traffic
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", out_flat, '0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step("post_reset_first", 64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 3'd0, 3'd0,
           1'b1, 1'b0, 1'b1, pack_out(64'h0, 64'h0, 3'd0, 3'd0, 1'b1, 16'd1, 8'h00));
      for (int i = 0; i < 30; i++) rand_step("rand_post", 3);

      // Counter wrap from a fresh reset
      @(negedge clk);
      rst_n = 1'b0;
      in_flat = '0;
      @(negedge clk);
      rst_n = 1'b1;
      in_flat[134] = 1'b1;
      repeat (65536) @(posedge clk);
      @(negedge clk);
      cnt_seen = out_flat[150:135];
      check("cnt_wrap_65536", {143'd0, cnt_seen}, {143'd0, 16'h0000});
      @(posedge clk);
      #1;
      in_flat[134] = 1'b0;
      cnt_seen = out_flat[150:135];
      check("cnt_wrap_65537", {143'd0, cnt_seen}, {143'd0, 16'h0001});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
